// File: rtl/timer_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_sched_pkg
// Description : Shared types and helpers for the timer scheduler: FSM state
//               encoding and a one-hot decoder sized for the largest
//               supported requester count.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_sched_pkg;

  // Largest supported requester count and the index width that covers it.
  localparam int C_MAX_N = 16;
  localparam int C_IDX_W = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // One-hot decode at full width; callers truncate to their own N.
  function automatic logic [C_MAX_N-1:0] onehot(input logic [C_IDX_W-1:0] idx);
    logic [C_MAX_N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/timer_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : timer_scheduler_if
// Description : Client-facing bundle of the timer scheduler.
//               master : client side  (drives req, len, flush)
//               slave  : scheduler    (drives gnt, done, busy, cur_id)
//   req    N      level request per client
//   len    N*W    packed delay per client, client i at [i*W +: W]
//   flush  1      abort the running delay
//   gnt    N      one-hot grant pulse
//   done   N      one-hot completion pulse
//   busy   1      a delay is running
//   cur_id clog2N client being served (valid while busy)
// Revision    : 1.0 - initial release
// ============================================================================
interface timer_scheduler_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int C_ID_W = $clog2(N);

  logic [N-1:0]      req;
  logic [N*W-1:0]    len;
  logic              flush;
  logic [N-1:0]      gnt;
  logic [N-1:0]      done;
  logic              busy;
  logic [C_ID_W-1:0] cur_id;

  modport master (
    output req, len, flush,
    input  gnt, done, busy, cur_id
  );

  modport slave (
    input  req, len, flush,
    output gnt, done, busy, cur_id
  );
endinterface
`default_nettype wire

// File: rtl/timer_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick. The lowest requesting index
//               at or above ptr wins; if none, the lowest requesting index
//               overall wins.
//   req       in  N        request vector
//   ptr       in  clog2N   priority start index
//   grant_idx out clog2N   winning index (0 when any is low)
//   any       out 1        at least one request is set
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any
);
  localparam int C_ID_W = $clog2(N);

  logic              hit_hi;
  logic [C_ID_W-1:0] idx_hi;
  logic [C_ID_W-1:0] idx_lo;

  // Scanning downward means the last hit written is the lowest index, both
  // for the "at or above ptr" half and for the wrapped fallback.
  always_comb begin
    hit_hi = 1'b0;
    idx_hi = '0;
    idx_lo = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx_lo = C_ID_W'(i);
        if (i >= int'(ptr)) begin
          hit_hi = 1'b1;
          idx_hi = C_ID_W'(i);
        end
      end
    end
    grant_idx = hit_hi ? idx_hi : idx_lo;
    any       = |req;
  end

endmodule
`default_nettype wire

// File: rtl/timer_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : timer_scheduler
// Description : One down-counting delay timer shared by N clients. Grants
//               one client at a time round-robin, runs its delay of
//               max(len,1) cycles and pulses that client's done bit.
//   clk   in  1   clock, rising edge
//   rst   in  1   asynchronous active-high reset
//   bus   slave   client bundle (req/len/flush in, gnt/done/busy/cur_id out)
// Revision    : 1.0 - initial release
// ============================================================================
module timer_scheduler #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic              clk,
  input  logic              rst,
  timer_scheduler_if.slave  bus
);
  import timer_sched_pkg::*;

  localparam int C_ID_W = $clog2(N);

  state_t            state_q,  state_d;
  logic [W-1:0]      cnt_q,    cnt_d;
  logic [C_ID_W-1:0] ptr_q,    ptr_d;
  logic [C_ID_W-1:0] cur_id_q, cur_id_d;
  logic [N-1:0]      gnt_q,    gnt_d;
  logic [N-1:0]      done_q,   done_d;
  logic              busy_q,   busy_d;

  logic [C_ID_W-1:0] win_idx;
  logic              win_any;
  logic [W-1:0]      win_len;
  logic [C_ID_W-1:0] next_id;

  rr_arbiter #(.N(N)) u_arb (
    .req       (bus.req),
    .ptr       (ptr_q),
    .grant_idx (win_idx),
    .any       (win_any)
  );

  assign win_len = bus.len[win_idx*W +: W];
  // Wrap explicitly so non-power-of-two N also rotates correctly.
  assign next_id = (cur_id_q == C_ID_W'(N - 1)) ? '0 : cur_id_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    cur_id_d = cur_id_q;
    gnt_d    = '0;
    done_d   = '0;
    busy_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (win_any) begin
          cur_id_d = win_idx;
          // A zero length runs like a length of one; the count holds L-1.
          cnt_d    = (win_len == '0) ? '0 : win_len - 1'b1;
          gnt_d    = N'(onehot(C_IDX_W'(win_idx)));
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (bus.flush) begin
          ptr_d   = next_id;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          done_d  = N'(onehot(C_IDX_W'(cur_id_q)));
          ptr_d   = next_id;
          state_d = IDLE;
        end else begin
          cnt_d  = cnt_q - 1'b1;
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      cur_id_q <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      cur_id_q <= cur_id_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;
  assign bus.cur_id = cur_id_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_scheduler
// Description : Self-checking bench for timer_scheduler (N=4, W=8): a table
//               of per-cycle vectors, directed multi-cycle sequences, and a
//               randomized run against a window-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_scheduler;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  timer_scheduler_if #(.N(N), .W(W)) bus ();

  timer_scheduler #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // One row: inputs held for one cycle, outputs expected in the next cycle.
  typedef struct {
    bit          do_rst;
    logic [3:0]  req;
    logic [31:0] len;
    logic [3:0]  gnt;
    logic [3:0]  done;
    bit          busy;
    logic [1:0]  id;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit r, logic [3:0] rq, logic [31:0] ln,
                              logic [3:0] g, logic [3:0] d, bit b, logic [1:0] id);
    vec_t v;
    v.do_rst = r; v.req = rq; v.len = ln;
    v.gnt = g; v.done = d; v.busy = b; v.id = id;
    tbl.push_back(v);
  endfunction

  // ------------------------------------------------------------------
  // Reference model: a run is described by its start cycle, length and
  // owner; outputs follow from where the current cycle falls in that window.
  // ------------------------------------------------------------------
  longint mc;
  bit     m_run;
  longint m_start;
  longint m_len;
  int     m_id;
  int     m_ptr;

  function automatic void model_reset();
    mc = 0; m_run = 0; m_start = 0; m_len = 1; m_id = 0; m_ptr = 0;
  endfunction

  function automatic void model_edge(logic [3:0] rq, logic [31:0] ln, logic fl);
    longint p;
    bit running;
    int w;
    int l;
    p  = mc;
    mc = mc + 1;
    running = m_run && (p >= m_start) && (p <= m_start + m_len - 1);
    if (running) begin
      if (fl) begin
        m_run = 0;
        m_ptr = (m_id + 1) % N;
      end else if (p == m_start + m_len - 1) begin
        m_ptr = (m_id + 1) % N;
      end
    end else if (rq != 0) begin
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && rq[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      l       = int'(ln[w*W +: W]);
      m_run   = 1;
      m_start = mc;
      m_len   = (l == 0) ? 1 : l;
      m_id    = w;
    end
  endfunction

  function automatic logic [3:0] exp_gnt();
    return (m_run && mc == m_start) ? 4'(1 << m_id) : 4'b0;
  endfunction
  function automatic logic [3:0] exp_done();
    return (m_run && mc == m_start + m_len) ? 4'(1 << m_id) : 4'b0;
  endfunction
  function automatic logic exp_busy();
    return m_run && mc >= m_start && mc <= m_start + m_len - 1;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    bus.req   = '0;
    bus.flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset.gnt",    32'(bus.gnt),    32'h0);
    chk("reset.done",   32'(bus.done),   32'h0);
    chk("reset.busy",   32'(bus.busy),   32'h0);
    chk("reset.cur_id", 32'(bus.cur_id), 32'h0);
  endtask

  logic [31:0] l2;
  logic [31:0] rl;
  logic [3:0]  rq;
  logic        rf;

  initial begin
    rst       = 1'b1;
    bus.req   = '0;
    bus.len   = '0;
    bus.flush = 1'b0;

    // Single request, length 5, request dropped after grant.
    add(1, 4'b0001, 32'h0000_0005, 4'b0001, 4'b0000, 1, 2'd0);
    add(0, 4'b0000, 32'h0000_0005, 4'b0000, 4'b0000, 1, 2'd0);
    add(0, 4'b0000, 32'h0000_0005, 4'b0000, 4'b0000, 1, 2'd0);
    add(0, 4'b0000, 32'h0000_0005, 4'b0000, 4'b0000, 1, 2'd0);
    add(0, 4'b0000, 32'h0000_0005, 4'b0000, 4'b0000, 1, 2'd0);
    add(0, 4'b0000, 32'h0000_0005, 4'b0000, 4'b0001, 0, 2'd0);
    add(0, 4'b0000, 32'h0000_0005, 4'b0000, 4'b0000, 0, 2'd0);
    // Contention 1011, all lengths 2, held: grants 0,1,3,0 every 3 cycles.
    l2 = 32'h0202_0202;
    add(1, 4'b1011, l2, 4'b0001, 4'b0000, 1, 2'd0);
    add(0, 4'b1011, l2, 4'b0000, 4'b0000, 1, 2'd0);
    add(0, 4'b1011, l2, 4'b0000, 4'b0001, 0, 2'd0);
    add(0, 4'b1011, l2, 4'b0010, 4'b0000, 1, 2'd1);
    add(0, 4'b1011, l2, 4'b0000, 4'b0000, 1, 2'd1);
    add(0, 4'b1011, l2, 4'b0000, 4'b0010, 0, 2'd1);
    add(0, 4'b1011, l2, 4'b1000, 4'b0000, 1, 2'd3);
    add(0, 4'b1011, l2, 4'b0000, 4'b0000, 1, 2'd3);
    add(0, 4'b1011, l2, 4'b0000, 4'b1000, 0, 2'd3);
    add(0, 4'b1011, l2, 4'b0001, 4'b0000, 1, 2'd0);
    add(0, 4'b0000, l2, 4'b0000, 4'b0000, 1, 2'd0);
    add(0, 4'b0000, l2, 4'b0000, 4'b0001, 0, 2'd0);
    add(0, 4'b0000, l2, 4'b0000, 4'b0000, 0, 2'd0);
    // Zero length on client 2 behaves like length 1.
    add(1, 4'b0100, 32'h0000_0000, 4'b0100, 4'b0000, 1, 2'd2);
    add(0, 4'b0000, 32'h0000_0000, 4'b0000, 4'b0100, 0, 2'd2);
    add(0, 4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 0, 2'd2);
    add(0, 4'b0100, 32'h0001_0000, 4'b0100, 4'b0000, 1, 2'd2);
    add(0, 4'b0000, 32'h0001_0000, 4'b0000, 4'b0100, 0, 2'd2);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].do_rst) do_reset();
      bus.req = tbl[i].req;
      bus.len = tbl[i].len;
      step();
      chk($sformatf("tbl[%0d].gnt", i),  32'(bus.gnt),  32'(tbl[i].gnt));
      chk($sformatf("tbl[%0d].done", i), 32'(bus.done), 32'(tbl[i].done));
      chk($sformatf("tbl[%0d].busy", i), 32'(bus.busy), 32'(tbl[i].busy));
      if (tbl[i].busy)
        chk($sformatf("tbl[%0d].cur_id", i), 32'(bus.cur_id), 32'(tbl[i].id));
    end

    // Flush: client 1 len 10, flush three cycles after grant, client 2 next.
    do_reset();
    bus.len = {8'd0, 8'd3, 8'd10, 8'd0};
    bus.req = 4'b0110;
    step();
    chk("flush.gnt1", 32'(bus.gnt),    32'b0010);
    chk("flush.id1",  32'(bus.cur_id), 32'd1);
    bus.req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flush.busy_run", 32'(bus.busy), 32'd1);
      chk("flush.no_done",  32'(bus.done), 32'd0);
    end
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("flush.busy_drop", 32'(bus.busy), 32'd0);
    chk("flush.done_zero", 32'(bus.done), 32'd0);
    step();
    chk("flush.gnt2", 32'(bus.gnt),    32'b0100);
    chk("flush.id2",  32'(bus.cur_id), 32'd2);
    bus.req = 4'b0000;
    step();
    step();
    chk("flush.busy2", 32'(bus.busy), 32'd1);
    step();
    chk("flush.done2", 32'(bus.done), 32'b0100);

    // Reset mid-run: first move ptr to 3, then abandon a run with async rst.
    do_reset();
    bus.len = {8'd0, 8'd1, 8'd0, 8'd8};
    bus.req = 4'b0100;
    step();
    bus.req = 4'b0000;
    step();
    chk("rstmid.pre_done", 32'(bus.done), 32'b0100);
    bus.req = 4'b0001;
    step();
    chk("rstmid.gnt0", 32'(bus.gnt), 32'b0001);
    bus.req = 4'b0000;
    step();
    step();
    chk("rstmid.busy", 32'(bus.busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid.gnt_clr",  32'(bus.gnt),    32'd0);
    chk("rstmid.done_clr", 32'(bus.done),   32'd0);
    chk("rstmid.busy_clr", 32'(bus.busy),   32'd0);
    chk("rstmid.id_clr",   32'(bus.cur_id), 32'd0);
    step();
    rst = 1'b0;
    bus.len = {8'd2, 8'd0, 8'd0, 8'd2};
    bus.req = 4'b1001;
    step();
    chk("rstmid.ptr0_gnt", 32'(bus.gnt), 32'b0001);
    step();
    step();
    chk("rstmid.done0", 32'(bus.done), 32'b0001);
    step();
    chk("rstmid.gnt3", 32'(bus.gnt), 32'b1000);
    bus.req = 4'b0000;
    step();
    step();
    chk("rstmid.done3", 32'(bus.done), 32'b1000);

    // Stale length: len changes after grant must not affect the run.
    do_reset();
    bus.len = 32'h0000_0004;
    bus.req = 4'b0001;
    step();
    chk("stale.gnt", 32'(bus.gnt), 32'b0001);
    bus.len = 32'h0000_0009;
    bus.req = 4'b0000;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("stale.busy", 32'(bus.busy), 32'd1);
      chk("stale.done_early", 32'(bus.done), 32'd0);
    end
    step();
    chk("stale.done", 32'(bus.done), 32'b0001);
    chk("stale.busy_low", 32'(bus.busy), 32'd0);
    step();
    chk("stale.after", 32'(bus.done), 32'd0);

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      rq = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom);
      for (int k = 0; k < N; k++)
        rl[k*W +: W] = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 40))
                                                    : 8'($urandom_range(0, 5));
      rf = ($urandom_range(0, 15) == 0);
      bus.req   = rq;
      bus.len   = rl;
      bus.flush = rf;
      step();
      model_edge(rq, rl, rf);
      chk("rand.gnt",  32'(bus.gnt),  32'(exp_gnt()));
      chk("rand.done", 32'(bus.done), 32'(exp_done()));
      chk("rand.busy", 32'(bus.busy), 32'(exp_busy()));
      if (exp_busy())
        chk("rand.cur_id", 32'(bus.cur_id), 32'(m_id));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
